// File: rtl/display_scan.sv
// ============================================================================
// display_scan : time-multiplexed 4-digit BCD display scanner with blanking,
//                blinking and leading-zero suppression.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [3:0]  num,
  output logic        frame_done
);

  localparam int C_CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int C_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(REFRESH_DIV - 1);
  localparam logic [C_FRM_W-1:0] C_FRM_MAX = C_FRM_W'(BLINK_FRAMES - 1);

  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [C_FRM_W-1:0] frm_q, frm_d;
  logic               blink_q, blink_d;
  logic [3:0]         an_q, an_d;
  logic [3:0]         num_q, num_d;
  logic               fd_q, fd_d;

  logic               w_tick;
  logic               w_wrap;
  logic [1:0]         w_next_idx;
  logic [3:0]         w_nib [4];
  logic [3:0]         w_lz;
  logic [3:0]         w_dark;

  // Per-slot digit value and darkness, all from pre-edge state
  for (genvar j = 0; j < 4; j++) begin : g_slot
    assign w_nib[j] = shadow_q[4*j +: 4];
    if (j == 0) begin : g_lsd
      assign w_lz[j] = 1'b0;
    end else begin : g_upper
      assign w_lz[j] = lz_en & (shadow_q[15:4*j] == '0);
    end
    assign w_dark[j] = blank_mask[j] | (blink_mask[j] & blink_q) | w_lz[j];
  end

  always_comb begin
    w_tick     = (cnt_q == C_CNT_MAX);
    w_wrap     = w_tick && (idx_q == 2'd3);
    w_next_idx = idx_q + 2'd1;

    cnt_d    = w_tick ? '0 : cnt_q + C_CNT_W'(1);
    idx_d    = w_tick ? w_next_idx : idx_q;
    shadow_d = load ? digits : shadow_q;
    fd_d     = w_wrap;

    frm_d   = frm_q;
    blink_d = blink_q;
    if (w_wrap) begin
      if (frm_q == C_FRM_MAX) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + C_FRM_W'(1);
      end
    end

    an_d  = an_q;
    num_d = num_q;
    if (w_tick) begin
      if (w_dark[w_next_idx]) begin
        an_d  = 4'b1111;
        num_d = 4'hF;
      end else begin
        an_d  = ~(4'b0001 << w_next_idx);
        num_d = w_nib[w_next_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      frm_q    <= '0;
      blink_q  <= 1'b0;
      an_q     <= 4'b1110;
      num_q    <= 4'h0;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frm_q    <= frm_d;
      blink_q  <= blink_d;
      an_q     <= an_d;
      num_q    <= num_d;
      fd_q     <= fd_d;
    end
  end

  assign an         = an_q;
  assign num        = num_q;
  assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
// tb_display_scan : directed scenarios plus randomized run against a
//                   behavioural model of the display scanner.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_display_scan;

  localparam int RD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [3:0]  num;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_cnt, m_idx, m_frames;
  bit          m_phase;
  logic [15:0] m_sh;
  logic [3:0]  m_an, m_num;
  logic        m_fd;

  always #5 clk = ~clk;

  display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits(digits), .load(load),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .an(an), .num(num), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // What digit slot j displays, straight from the display rules
  function automatic void slot_value(input int j, input logic [15:0] sh,
                                     input logic [3:0] blank, input logic [3:0] blink,
                                     input bit lz, input bit phase,
                                     output logic [3:0] a, output logic [3:0] n);
    logic [15:0] upper;
    bit dark;
    upper = sh >> (4 * j);
    dark  = blank[j] || (blink[j] && phase) || (lz && j >= 1 && upper == 16'h0);
    if (dark) begin
      a = 4'b1111;
      n = 4'hF;
    end else begin
      a = 4'b1111 & ~(4'(1) << j);
      n = upper[3:0];
    end
  endfunction

  // One clock: model consumes the pre-edge inputs, then DUT is compared
  task automatic step();
    logic        r, ld, lz;
    logic [15:0] d;
    logic [3:0]  bl, bk;
    int          zeros;
    r = rst; ld = load; d = digits; bl = blank_mask; bk = blink_mask; lz = lz_en;
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = 0; m_idx = 0; m_sh = 16'h0; m_frames = 0; m_phase = 0;
      m_an = 4'b1110; m_num = 4'h0; m_fd = 1'b0;
    end else begin
      m_fd = (m_cnt == RD - 1) && (m_idx == 3);
      if (m_cnt == RD - 1) begin
        m_idx = (m_idx + 1) % 4;
        slot_value(m_idx, m_sh, bl, bk, lz, m_phase, m_an, m_num);
        if (m_idx == 0) begin
          m_frames = m_frames + 1;
          if (m_frames == BF) begin
            m_frames = 0;
            m_phase  = !m_phase;
          end
        end
      end
      m_cnt = (m_cnt + 1) % RD;
      if (ld) m_sh = d;
    end
    check("an", 32'(an), 32'(m_an));
    check("num", 32'(num), 32'(m_num));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    zeros = 0;
    for (int i = 0; i < 4; i++) if (an[i] === 1'b0) zeros++;
    check("an_single_low", 32'(zeros <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; step();
    check("rst_an", 32'(an), 32'hE);
    check("rst_num", 32'(num), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Scan order with 1234
    load = 1'b1; digits = 16'h1234; step();
    load = 1'b0; run(3);
    check("scan1_an", 32'(an), 32'hD);   check("scan1_num", 32'(num), 32'h3);
    run(4);
    check("scan2_an", 32'(an), 32'hB);   check("scan2_num", 32'(num), 32'h2);
    run(4);
    check("scan3_an", 32'(an), 32'h7);   check("scan3_num", 32'(num), 32'h1);
    run(4);
    check("scan0_an", 32'(an), 32'hE);   check("scan0_num", 32'(num), 32'h4);
    check("scan_fd", 32'(frame_done), 32'h1);
    run(1);
    check("scan_fd_gone", 32'(frame_done), 32'h0);

    // Load during a tick cycle: next slot still shows old digit
    run(2);
    load = 1'b1; digits = 16'h9999; step();
    load = 1'b0;
    check("ldtick_old", 32'(num), 32'h3);
    run(4);
    check("ldtick_new", 32'(num), 32'h9);

    // Mid-frame reset holds slot 0 for a full refresh count
    run(2);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_an", 32'(an), 32'hE);
      check("midrst_num", 32'(num), 32'h0);
    end
    step();
    check("midrst_adv", 32'(an), 32'hD);

    // Leading-zero suppression on 0070
    rst = 1'b1; step(); rst = 1'b0;
    lz_en = 1'b1; load = 1'b1; digits = 16'h0070; step();
    load = 1'b0; run(3);
    check("lz_s1_an", 32'(an), 32'hD);   check("lz_s1_num", 32'(num), 32'h7);
    run(4);
    check("lz_s2_an", 32'(an), 32'hF);   check("lz_s2_num", 32'(num), 32'hF);
    run(4);
    check("lz_s3_an", 32'(an), 32'hF);   check("lz_s3_num", 32'(num), 32'hF);
    run(4);
    check("lz_s0_an", 32'(an), 32'hE);   check("lz_s0_num", 32'(num), 32'h0);
    lz_en = 1'b0;

    // Blink on digit 0 across several half-periods
    rst = 1'b1; step(); rst = 1'b0;
    blink_mask = 4'b0001; load = 1'b1; digits = 16'h0005; step();
    load = 1'b0; run(16 * 9);
    blink_mask = 4'h0;

    // Randomized run
    for (int it = 0; it < 3000; it++) begin
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++)
        digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 47) == 0) begin
        blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        blink_mask = 4'($urandom_range(0, 15));
        lz_en      = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
